alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 131 +++++++++++++
 tb/tb_alu_issue.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// ============================================================================
// Module   : alu_issue
// Brief    : Decode-to-EX issue register with ALU control decode, operand
//            forwarding and a valid/ready handshake on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [3:0]       funct,
  input  logic             ALUSrc,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [WIDTH-1:0] imm,
  input  logic [1:0]       fwd_a,
  input  logic [1:0]       fwd_b,
  input  logic [WIDTH-1:0] ex_fwd,
  input  logic [WIDTH-1:0] mem_fwd,
  input  logic             flush,
  output logic [WIDTH-1:0] input1,
  output logic [WIDTH-1:0] input2,
  output logic [2:0]       ALUControl,
  output logic             illegal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] issued_count
);

  logic             out_valid_q;
  logic [WIDTH-1:0] input1_q, input1_d;
  logic [WIDTH-1:0] input2_q, input2_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q;
  logic             accept;
  logic             drain;

  assign in_ready = (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready && !flush;

  always_comb begin
    ctrl_d    = 3'b010;
    illegal_d = 1'b0;
    unique case (ALUOp)
      2'b00: ctrl_d = 3'b010;
      2'b01: ctrl_d = 3'b110;
      2'b11: ctrl_d = 3'b001;
      default: begin
        unique case (funct)
          4'b0000: ctrl_d = 3'b000;
          4'b0001: ctrl_d = 3'b001;
          4'b0010: ctrl_d = 3'b010;
          4'b0110: ctrl_d = 3'b110;
          4'b0111: ctrl_d = 3'b111;
          default: begin
            ctrl_d    = 3'b010;
            illegal_d = 1'b1;
          end
        endcase
      end
    endcase
  end

  always_comb begin
    input1_d = rs_data;
    unique case (fwd_a)
      2'b01:   input1_d = ex_fwd;
      2'b10:   input1_d = mem_fwd;
      default: input1_d = rs_data;
    endcase
  end

  // The immediate path bypasses forwarding entirely.
  always_comb begin
    input2_d = rt_data;
    if (ALUSrc) begin
      input2_d = imm;
    end else begin
      unique case (fwd_b)
        2'b01:   input2_d = ex_fwd;
        2'b10:   input2_d = mem_fwd;
        default: input2_d = rt_data;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      input1_q    <= '0;
      input2_q    <= '0;
      ctrl_q      <= 3'b000;
      illegal_q   <= 1'b0;
      count_q     <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        input1_q    <= input1_d;
        input2_q    <= input2_d;
        ctrl_q      <= ctrl_d;
        illegal_q   <= illegal_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (drain) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign input1       = input1_q;
  assign input2       = input2_q;
  assign ALUControl   = ctrl_q;
  assign illegal      = illegal_q;
  assign issued_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// ============================================================================
// Module   : tb_alu_issue
// Brief    : Scoreboard bench for alu_issue: expected issues are queued on
//            accept and compared while the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  ALUOp = 2'b00;
  logic [3:0]  funct = 4'b0000;
  logic        ALUSrc = 1'b0;
  logic [15:0] rs_data = '0, rt_data = '0, imm = '0, ex_fwd = '0, mem_fwd = '0;
  logic [1:0]  fwd_a = 2'b00, fwd_b = 2'b00;
  logic        flush = 1'b0;
  logic [15:0] input1, input2;
  logic [2:0]  ALUControl;
  logic        illegal;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] issued_count;

  alu_issue #(.WIDTH(16), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .funct(funct), .ALUSrc(ALUSrc), .rs_data(rs_data),
    .rt_data(rt_data), .imm(imm), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .ex_fwd(ex_fwd), .mem_fwd(mem_fwd), .flush(flush), .input1(input1),
    .input2(input2), .ALUControl(ALUControl), .illegal(illegal),
    .out_valid(out_valid), .out_ready(out_ready), .issued_count(issued_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  c;
    logic        il;
  } exp_t;

  exp_t        sb[$];
  logic        exp_ov = 1'b0;
  logic [15:0] exp_cnt = '0;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic exp_t model();
    exp_t e;
    e.il = 1'b0;
    if (ALUOp == 2'b00)      e.c = 3'b010;
    else if (ALUOp == 2'b01) e.c = 3'b110;
    else if (ALUOp == 2'b11) e.c = 3'b001;
    else begin
      if (funct == 4'b0000)      e.c = 3'b000;
      else if (funct == 4'b0001) e.c = 3'b001;
      else if (funct == 4'b0010) e.c = 3'b010;
      else if (funct == 4'b0110) e.c = 3'b110;
      else if (funct == 4'b0111) e.c = 3'b111;
      else begin e.c = 3'b010; e.il = 1'b1; end
    end
    e.a = (fwd_a == 2'b01) ? ex_fwd : (fwd_a == 2'b10) ? mem_fwd : rs_data;
    if (ALUSrc) e.b = imm;
    else e.b = (fwd_b == 2'b01) ? ex_fwd : (fwd_b == 2'b10) ? mem_fwd : rt_data;
    return e;
  endfunction

  task automatic randomize_data();
    rs_data = 16'($urandom); rt_data = 16'($urandom); imm = 16'($urandom);
    ex_fwd = 16'($urandom); mem_fwd = 16'($urandom);
    fwd_a = 2'($urandom); fwd_b = 2'($urandom); ALUSrc = 1'($urandom);
  endtask

  // One clock cycle: check what the DUT presents, then advance the model.
  task automatic step();
    logic exp_rdy, acc, drn;
    exp_t e;
    #1;
    exp_rdy = (!exp_ov || out_ready) && !flush;
    vectors++;
    if (in_ready !== exp_rdy) begin
      miscompares++; $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_rdy, $time);
    end
    vectors++;
    if (out_valid !== exp_ov) begin
      miscompares++; $display("FAIL out_valid: got %b expected %b at %0t", out_valid, exp_ov, $time);
    end
    vectors++;
    if (issued_count !== exp_cnt) begin
      miscompares++; $display("FAIL issued_count: got %h expected %h at %0t", issued_count, exp_cnt, $time);
    end
    if (exp_ov && sb.size() > 0) begin
      vectors++;
      if ({input1, input2, ALUControl, illegal} !== sb[0]) begin
        miscompares++;
        $display("FAIL issue_data: got %h/%h/%b/%b expected %h/%h/%b/%b at %0t",
                 input1, input2, ALUControl, illegal, sb[0].a, sb[0].b, sb[0].c, sb[0].il, $time);
      end
    end
    acc = in_valid && exp_rdy;
    drn = exp_ov && out_ready && !flush;
    e = model();
    @(posedge clock);
    #1;
    if (flush) begin
      sb.delete();
      exp_ov = 1'b0;
    end else begin
      if (drn) begin
        void'(sb.pop_front());
        exp_cnt = exp_cnt + 16'd1;
      end
      if (acc) begin
        sb.push_back(e);
        exp_ov = 1'b1;
      end else if (out_ready) begin
        exp_ov = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    sb.delete();
    exp_ov = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({out_valid, input1, input2, ALUControl, illegal, issued_count} !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got ov=%b %h %h %b %b %h expected all zero",
                              out_valid, input1, input2, ALUControl, illegal, issued_count);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clock); #2;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_sub();
    in_valid = 1'b1; ALUOp = 2'b10; funct = 4'b0110; ALUSrc = 1'b0;
    rs_data = 16'h0009; rt_data = 16'h0004; fwd_a = 2'b00; fwd_b = 2'b00;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++;
    if ({out_valid, input1, input2, ALUControl} !== {1'b1, 16'h0009, 16'h0004, 3'b110}) begin
      miscompares++; $display("FAIL sub_issue: got ov=%b %h %h %b expected 1 0009 0004 110",
                              out_valid, input1, input2, ALUControl);
    end
    step();
  endtask

  task automatic test_imm_fwd();
    in_valid = 1'b1; ALUOp = 2'b00; ALUSrc = 1'b1; imm = 16'hFFFE;
    fwd_a = 2'b01; ex_fwd = 16'h1234; fwd_b = 2'b10; mem_fwd = 16'h5555;
    step();
    in_valid = 1'b0;
    vectors++;
    if ({input1, input2, ALUControl} !== {16'h1234, 16'hFFFE, 3'b010}) begin
      miscompares++; $display("FAIL imm_fwd: got %h %h %b expected 1234 FFFE 010",
                              input1, input2, ALUControl);
    end
    step();
  endtask

  task automatic test_decode_all();
    out_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      for (int f = 0; f < 16; f++) begin
        in_valid = 1'b1; ALUOp = 2'(op); funct = 4'(f);
        randomize_data();
        step();
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] h1, h2;
    logic [2:0]  hc;
    in_valid = 1'b1; out_ready = 1'b1; ALUOp = 2'b11; randomize_data();
    step();
    h1 = input1; h2 = input2; hc = ALUControl;
    out_ready = 1'b0; ALUOp = 2'b01; randomize_data();
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({in_ready, input1, input2, ALUControl} !== {1'b0, h1, h2, hc}) begin
        miscompares++; $display("FAIL stall_hold: got rdy=%b %h %h %b expected 0 %h %h %b",
                                in_ready, input1, input2, ALUControl, h1, h2, hc);
      end
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++;
    if (ALUControl !== 3'b110 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL stall_release: got ctrl=%b ov=%b expected 110 1", ALUControl, out_valid);
    end
    step();
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; out_ready = 1'b1; ALUOp = 2'b10; funct = 4'b1111; randomize_data();
    step();
    vectors++;
    if ({ALUControl, illegal} !== {3'b010, 1'b1}) begin
      miscompares++; $display("FAIL illegal_set: got %b %b expected 010 1", ALUControl, illegal);
    end
    funct = 4'b0111;
    step();
    in_valid = 1'b0;
    vectors++;
    if ({ALUControl, illegal} !== {3'b111, 1'b0}) begin
      miscompares++; $display("FAIL illegal_clear: got %b %b expected 111 0", ALUControl, illegal);
    end
    step();
  endtask

  task automatic test_flush();
    logic [15:0] c0;
    in_valid = 1'b1; out_ready = 1'b1; ALUOp = 2'b00; randomize_data();
    step();
    c0 = issued_count;
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || issued_count !== c0) begin
      miscompares++; $display("FAIL flush: got ov=%b cnt=%h expected 0 %h", out_valid, issued_count, c0);
    end
    step();
  endtask

  task automatic test_reset_mid_stall();
    in_valid = 1'b1; out_ready = 1'b0; ALUOp = 2'b11; randomize_data();
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, input1, input2, ALUControl, illegal, issued_count} !== '0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL async_reset: got ov=%b %h %h %b %b %h rdy=%b expected zeros rdy=1",
                              out_valid, input1, input2, ALUControl, illegal, issued_count, in_ready);
    end
    #1 reset_n = 1'b1;
    model_reset();
    out_ready = 1'b1; ALUOp = 2'b01;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || ALUControl !== 3'b110) begin
      miscompares++; $display("FAIL resume_after_reset: got ov=%b ctrl=%b expected 1 110", out_valid, ALUControl);
    end
    step();
  endtask

  task automatic test_wrap();
    int guard = 0;
    in_valid = 1'b1; out_ready = 1'b1; ALUOp = 2'b00;
    while (exp_cnt != 16'hFFFF && guard < 70000) begin
      step();
      guard++;
    end
    if (guard >= 70000) begin
      vectors++; miscompares++;
      $display("FAIL wrap_budget: got count %h expected to reach FFFF", issued_count);
    end
    vectors++;
    if (issued_count !== 16'hFFFF) begin
      miscompares++; $display("FAIL wrap_pre: got %h expected FFFF", issued_count);
    end
    step();
    vectors++;
    if (issued_count !== 16'h0000) begin
      miscompares++; $display("FAIL wrap: got %h expected 0000", issued_count);
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_sub();
    test_imm_fwd();
    test_decode_all();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid_stall();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
